// File: rtl/rv32i_types.sv
// Shared retirement-side types: architectural register count and commit/free lane records.
package rv32i_types;
    localparam int NUM_ARCH_REGS  = 32;
    localparam int ARCH_W         = 5;
    localparam int DEFAULT_PREG_W = 6;

    typedef struct packed {
        logic                      valid;
        logic [ARCH_W-1:0]         rd;
        logic [DEFAULT_PREG_W-1:0] pd;
        logic                      we;
    } commit_lane_t;

    typedef struct packed {
        logic                      valid;
        logic [DEFAULT_PREG_W-1:0] preg;
    } free_lane_t;
endpackage

// File: rtl/free_return_queue.sv
// Multi-push/multi-pop circular buffer of freed pregs; pushes visible one cycle after write.
// Backpressure: pop_rdy=0 holds head and outputs; caller must only push when SS slots are free.
module free_return_queue #(
    parameter int SS    = 2,
    parameter int DEPTH = 16,
    parameter int WIDTH = 6,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SS-1:0]              push_vld,
    input  logic [SS-1:0][WIDTH-1:0]   push_dat,
    input  logic                       pop_rdy,
    output logic [SS-1:0]              out_vld,
    output logic [SS-1:0][WIDTH-1:0]   out_dat,
    output logic [OCC_W-1:0]           occupancy
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] head, tail;
    logic [OCC_W-1:0] push_cnt, pop_cnt;

    // Offsets never exceed DEPTH, so one conditional subtract is enough for the wrap.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return IDX_W'(s);
    endfunction

    always_comb begin
        push_cnt = '0;
        for (int k = 0; k < SS; k++) begin
            if (push_vld[k]) push_cnt = push_cnt + OCC_W'(1);
        end
        pop_cnt = '0;
        if (pop_rdy) pop_cnt = (occupancy >= OCC_W'(SS)) ? OCC_W'(SS) : occupancy;
        for (int k = 0; k < SS; k++) begin
            out_vld[k] = occupancy > OCC_W'(k);
            out_dat[k] = mem[wrap_add(head, k)];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < SS; k++) begin
            if (!rst && push_vld[k]) mem[wrap_add(tail, k)] <= push_dat[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= wrap_add(head, int'(pop_cnt));
            tail      <= wrap_add(tail, int'(push_cnt));
            occupancy <= occupancy + push_cnt - pop_cnt;
        end
    end
endmodule

// File: rtl/rrat_commit.sv
// Retirement RAT: applies commit bundles to the committed map and queues displaced pregs.
// Map visible one cycle after accept; commit_ready drops when fewer than SS queue slots remain.
module rrat_commit
    import rv32i_types::*;
#(
    parameter int SS           = 2,
    parameter int NUM_PREGS    = 64,
    parameter int FREE_Q_DEPTH = 16,
    localparam int PREG_W = $clog2(NUM_PREGS),
    localparam int OCC_W  = $clog2(FREE_Q_DEPTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [SS-1:0]                         commit_valid,
    input  logic [SS-1:0][4:0]                    commit_rd,
    input  logic [SS-1:0][PREG_W-1:0]             commit_pd,
    input  logic [SS-1:0]                         commit_we,
    output logic                                  commit_ready,
    output logic [SS-1:0]                         free_valid,
    output logic [SS-1:0][PREG_W-1:0]             free_preg,
    input  logic                                  free_ready,
    output logic [NUM_ARCH_REGS-1:0][PREG_W-1:0]  rrat_map
);
    logic [NUM_ARCH_REGS-1:0][PREG_W-1:0] map_q, map_d;
    logic [SS-1:0]                        eff;
    logic [SS-1:0][PREG_W-1:0]            old_pd;
    logic [SS-1:0]                        push_vld;
    logic [SS-1:0][PREG_W-1:0]            push_dat;
    logic [OCC_W-1:0]                     occ;
    logic                                 accept;

    assign commit_ready = (FREE_Q_DEPTH - int'(occ)) >= SS;
    assign accept       = commit_valid[0] && commit_ready;

    always_comb begin
        logic live;
        int   cnt;
        map_d    = map_q;
        eff      = '0;
        old_pd   = '0;
        push_vld = '0;
        push_dat = '0;
        live     = accept;
        cnt      = 0;
        // Walking map_d lane by lane gives the intra-bundle bypass and last-writer-wins.
        for (int i = 0; i < SS; i++) begin
            live = live && commit_valid[i];
            if (live && commit_we[i] && commit_rd[i] != '0) begin
                eff[i]               = 1'b1;
                old_pd[i]            = map_d[commit_rd[i]];
                map_d[commit_rd[i]]  = commit_pd[i];
            end
        end
        for (int i = 0; i < SS; i++) begin
            if (eff[i]) begin
                for (int j = 0; j < SS; j++) begin
                    if (j == cnt) begin
                        push_vld[j] = 1'b1;
                        push_dat[j] = old_pd[i];
                    end
                end
                cnt = cnt + 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) map_q[i] <= PREG_W'(i);
        end else begin
            map_q <= map_d;
        end
    end

    assign rrat_map = map_q;

    free_return_queue #(
        .SS    (SS),
        .DEPTH (FREE_Q_DEPTH),
        .WIDTH (PREG_W)
    ) u_frq (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (push_vld),
        .push_dat  (push_dat),
        .pop_rdy   (free_ready),
        .out_vld   (free_valid),
        .out_dat   (free_preg),
        .occupancy (occ)
    );
endmodule

// File: tb/tb_rrat_commit.sv
// Bench for rrat_commit: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_rrat_commit;
    import rv32i_types::*;

    localparam int DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            commit_valid;
    logic [1:0][4:0]       commit_rd;
    logic [1:0][5:0]       commit_pd;
    logic [1:0]            commit_we;
    logic                  commit_ready;
    logic [1:0]            free_valid;
    logic [1:0][5:0]       free_preg;
    logic                  free_ready;
    logic [31:0][5:0]      rrat_map;

    int n_cmp = 0;
    int n_err = 0;
    int mmap[32];
    int q[$];

    rrat_commit #(.SS(2), .NUM_PREGS(64), .FREE_Q_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_pd    (commit_pd),
        .commit_we    (commit_we),
        .commit_ready (commit_ready),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
        .free_ready   (free_ready),
        .rrat_map     (rrat_map)
    );

    always #5 clk = ~clk;

    typedef struct {
        commit_lane_t l0;
        commit_lane_t l1;
        logic         fr;
        int           map_idx;
        int           map_val;
        logic [1:0]   fv;
        int           fp0;
        int           fp1;
    } vec_t;

    function automatic commit_lane_t mk(input logic v, input int rd, input int pd, input logic we);
        commit_lane_t l;
        l.valid = v;
        l.rd    = 5'(rd);
        l.pd    = 6'(pd);
        l.we    = we;
        return l;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input commit_lane_t l0, input commit_lane_t l1, input logic fr);
        commit_valid = {l1.valid, l0.valid};
        commit_rd    = {l1.rd, l0.rd};
        commit_pd    = {l1.pd, l0.pd};
        commit_we    = {l1.we, l0.we};
        free_ready   = fr;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mmap[i] = i;
        q.delete();
    endtask

    task automatic compare_model();
        int bad;
        check("commit_ready", int'(commit_ready), int'((DEPTH - q.size()) >= 2));
        check("free_valid", int'(free_valid), (q.size() > 1 ? 2 : 0) + (q.size() > 0 ? 1 : 0));
        for (int k = 0; k < 2; k++) begin
            if (q.size() > k) check($sformatf("free_preg[%0d]", k), int'(free_preg[k]), q[k]);
        end
        bad = -1;
        for (int i = 0; i < 32; i++) begin
            if (bad < 0 && int'(rrat_map[i]) != mmap[i]) bad = i;
        end
        if (bad >= 0)
            $display("  rrat_map[%0d] got %0d expected %0d", bad, rrat_map[bad], mmap[bad]);
        check("rrat_map first differing index", bad, -1);
    endtask

    // One clock: model consumes the pre-edge state and inputs, outputs compared 1ns after the edge.
    task automatic step();
        int npop;
        bit acc;
        assert (!(commit_valid[1] && !commit_valid[0])) else $error("non-contiguous commit lanes driven");
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc  = commit_valid[0] && ((DEPTH - q.size()) >= 2);
            npop = free_ready ? ((q.size() < 2) ? q.size() : 2) : 0;
            repeat (npop) void'(q.pop_front());
            if (acc) begin
                for (int i = 0; i < 2; i++) begin
                    if (!commit_valid[i]) break;
                    if (commit_we[i] && commit_rd[i] != 5'd0) begin
                        q.push_back(mmap[commit_rd[i]]);
                        mmap[commit_rd[i]] = int'(commit_pd[i]);
                    end
                end
            end
        end
        #1;
        compare_model();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[5];
        commit_lane_t z;
        int got[$];
        int bad;

        z = mk(0, 0, 0, 0);
        model_reset();
        rst = 1'b1;
        drive(z, z, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("reset commit_ready", int'(commit_ready), 1);
        check("reset free_valid", int'(free_valid), 0);
        bad = -1;
        for (int i = 0; i < 32; i++) if (bad < 0 && int'(rrat_map[i]) != i) bad = i;
        check("reset identity map first bad index", bad, -1);

        // Directed vectors from the identity map
        tbl[0] = '{l0: mk(1, 5, 40, 1), l1: mk(0, 0, 0, 0), fr: 1'b1,
                   map_idx: 5, map_val: 40, fv: 2'b01, fp0: 5, fp1: 0};
        tbl[1] = '{l0: mk(0, 0, 0, 0), l1: mk(0, 0, 0, 0), fr: 1'b1,
                   map_idx: 5, map_val: 40, fv: 2'b00, fp0: 0, fp1: 0};
        tbl[2] = '{l0: mk(1, 3, 33, 1), l1: mk(1, 3, 34, 1), fr: 1'b1,
                   map_idx: 3, map_val: 34, fv: 2'b11, fp0: 3, fp1: 33};
        tbl[3] = '{l0: mk(1, 0, 50, 1), l1: mk(1, 7, 9, 0), fr: 1'b1,
                   map_idx: 7, map_val: 7, fv: 2'b00, fp0: 0, fp1: 0};
        tbl[4] = '{l0: mk(0, 0, 0, 0), l1: mk(0, 0, 0, 0), fr: 1'b1,
                   map_idx: 3, map_val: 34, fv: 2'b00, fp0: 0, fp1: 0};
        for (int t = 0; t < 5; t++) begin
            drive(tbl[t].l0, tbl[t].l1, tbl[t].fr);
            step();
            check($sformatf("vec%0d map", t), int'(rrat_map[tbl[t].map_idx]), tbl[t].map_val);
            check($sformatf("vec%0d free_valid", t), int'(free_valid), int'(tbl[t].fv));
            if (tbl[t].fv[0]) check($sformatf("vec%0d free_preg0", t), int'(free_preg[0]), tbl[t].fp0);
            if (tbl[t].fv[1]) check($sformatf("vec%0d free_preg1", t), int'(free_preg[1]), tbl[t].fp1);
            check($sformatf("vec%0d commit_ready", t), int'(commit_ready), 1);
        end

        // Backpressure: fill all 16 slots (queue pointers sit mid-buffer, so the fill wraps)
        for (int b = 0; b < 8; b++) begin
            drive(mk(1, 8 + 2 * b, 10 + 2 * b, 1), mk(1, 9 + 2 * b, 11 + 2 * b, 1), 1'b0);
            step();
            if (b == 6) begin
                check("bp occ14 commit_ready", int'(commit_ready), 1);
                check("bp occ14 free_valid", int'(free_valid), 3);
            end
        end
        check("bp full commit_ready", int'(commit_ready), 0);
        drive(mk(1, 24, 63, 1), mk(0, 0, 0, 0), 1'b0);
        for (int c = 0; c < 2; c++) begin
            step();
            check("bp held commit not taken", int'(rrat_map[24]), 24);
            check("bp held commit_ready", int'(commit_ready), 0);
        end
        drive(z, z, 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (free_valid == 2'b00) break;
            for (int k = 0; k < 2; k++) if (free_valid[k]) got.push_back(int'(free_preg[k]));
            step();
            if (c == 0) check("bp drain commit_ready back", int'(commit_ready), 1);
        end
        check("bp drain finished", int'(free_valid), 0);
        check("bp drained count", got.size(), 16);
        bad = -1;
        for (int i = 0; i < got.size(); i++) if (bad < 0 && got[i] != 8 + i) bad = i;
        check("bp push order first bad position", bad, -1);

        // Reset mid-operation with six queued pregs and a modified map
        for (int b = 0; b < 3; b++) begin
            drive(mk(1, 1 + 2 * b, 41 + 2 * b, 1), mk(1, 2 + 2 * b, 42 + 2 * b, 1), 1'b0);
            step();
        end
        check("pre-reset free_valid", int'(free_valid), 3);
        check("pre-reset map[2]", int'(rrat_map[2]), 42);
        rst = 1'b1;
        drive(mk(1, 4, 44, 1), z, 1'b0);
        step();
        rst = 1'b0;
        drive(z, z, 1'b1);
        check("post-reset map[1]", int'(rrat_map[1]), 1);
        check("post-reset map[4]", int'(rrat_map[4]), 4);
        check("post-reset free_valid", int'(free_valid), 0);
        check("post-reset commit_ready", int'(commit_ready), 1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("post-reset no stale pregs", int'(free_valid), 0);
        end

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            commit_lane_t r0, r1;
            int vsel;
            int rds[2];
            logic fr;
            vsel = $urandom_range(0, 3);
            for (int i = 0; i < 2; i++)
                rds[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
            r0 = mk(vsel != 0, rds[0], $urandom_range(0, 63), 1'($urandom_range(0, 3) != 0));
            r1 = mk(vsel >= 2, rds[1], $urandom_range(0, 63), 1'($urandom_range(0, 3) != 0));
            fr = (c < 300) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 3) != 0);
            drive(r0, r1, fr);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rrat_commit.md
Name: rrat_commit

Overview:
- Retirement-side consumer of the ROB commit bundle. Holds the retirement RAT, which maps each architectural register to the physical register of its last committed writer.
- On each accepted commit it records the new architectural-to-physical mapping. The displaced physical register is pushed into an internal return queue, which drains to the free list.
- Also exports the full committed map for flush recovery of the speculative RAT.

Parameters:
SS, 2, superscalar width; commit lanes and free-return lanes
NUM_PREGS, 64, physical register count; PREG_W = $clog2(NUM_PREGS)
FREE_Q_DEPTH, 16, return-queue entries; must be >= 2*SS

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
commit_valid  in  [SS]  per-lane commit valid; lanes contiguous from lane 0
commit_rd  in  [SS][5]  architectural destination
commit_pd  in  [SS][PREG_W]  physical destination
commit_we  in  [SS]  instruction writes a register
commit_ready  out  1  bundle will be accepted this cycle
free_valid  out  [SS]  return lane k holds a freed preg
free_preg  out  [SS][PREG_W]  freed physical register
free_ready  in  1  free list consumes every valid lane this cycle
rrat_map  out  [32][PREG_W]  committed architectural map

Behaviour:
- Reset, synchronous, active-high:
  - map[i] = i for i = 0..31.
  - Queue empty; occupancy = 0; head/tail = 0.
  - free_valid = 0. commit_ready = 1 the cycle after rst deasserts.
  - Reset mid-operation discards queued pregs and in-flight bundles. No commit is accepted in the rst cycle.
- commit_ready = (FREE_Q_DEPTH - occupancy) >= SS. It is combinational from registered occupancy only, never from commit_valid.
- Accept condition: commit_valid[0] && commit_ready. The whole bundle is taken at once; there are no partial bundles.
- Non-contiguous valid lanes (e.g. lane 1 valid while lane 0 is not) are illegal. The bench asserts against this; RTL ignores lanes above the first invalid lane.
- Per accepted lane i, processed in lane order, a lane is "effective" iff commit_we[i] && commit_rd[i] != 0:
  - old = mapping of commit_rd[i] as seen after lanes 0..i-1. This is an intra-bundle bypass: if an earlier lane wrote the same rd, old = that lane's commit_pd.
  - Push old to the queue and set map[commit_rd[i]] = commit_pd[i].
  - The last lane writing a given rd wins in the map.
  - Non-effective lanes (x0 or no write) push nothing and leave the map unchanged.
- Pushes are compacted. Effective lanes occupy consecutive queue slots starting at tail, in lane order. tail advances by the push count (0..SS), modulo FREE_Q_DEPTH.
- Latency:
  - map update is visible on rrat_map the cycle after accept.
  - A freed preg is visible on free_* no earlier than the cycle after accept. There is no combinational commit-to-free path.
- Return side:
  - free_valid[k] = occupancy > k; free_preg[k] = queue[head+k].
  - When free_ready = 1, pop count = number of valid lanes; head advances modulo depth.
  - free_ready = 0 holds all outputs stable.
- Simultaneous push and pop in one cycle: occupancy_next = occupancy + pushes - pops. Occupancy is $clog2(FREE_Q_DEPTH+1) bits wide and never over- or underflows.
- Wrap-around: head/tail indices wrap modulo FREE_Q_DEPTH; multi-lane reads and writes straddling the wrap are handled per lane.
- commit_pd equal to the current mapping is not checked; the block pushes as specified.
- Flush: no input. The RRAT is architectural state and is unaffected. Consumers snapshot rrat_map.

Decomposition:
- Shared package rv32i_types gets:
  - NUM_ARCH_REGS = 32
  - typedef commit_lane_t {valid, rd, pd, we}
  - typedef free_lane_t {valid, preg}
- One sub-module, free_return_queue: a multi-push/multi-pop circular buffer with occupancy output. It is parameterised by SS, DEPTH and WIDTH.
- Map table and bypass logic stay in rrat_commit.

Test Plan:
- Reset, then idle -> rrat_map[i] = i for all i; free_valid = 0; commit_ready = 1.
- Lane0 commit rd=5, pd=40, we=1; free_ready=1 -> next cycle map[5]=40; free_valid=2'b01, free_preg[0]=5; following cycle queue empty.
- Bundle lane0 rd=3/pd=33 and lane1 rd=3/pd=34 -> map[3]=34; free_preg[0]=3, free_preg[1]=33, both valid.
- Lane0 rd=0/pd=50 we=1, lane1 rd=7 we=0 -> no push; map unchanged; free_valid=0.
- Backpressure: free_ready=0 (DEPTH=16, SS=2):
  - Issue 7 two-write bundles -> occupancy 14; commit_ready=1.
  - Issue an 8th bundle -> occupancy 16; commit_ready=0, and a held commit_valid is not accepted.
  - Raise free_ready -> 2 pops per cycle; commit_ready returns once occupancy <= 14; freed pregs emerge in push order across the wrap boundary.
- Queue holding 6 entries and map modified, then assert rst for 1 cycle -> map is identity, free_valid=0, occupancy=0; no stale pregs appear afterwards.
